// File: rtl/register_bank.sv
// Two-read, one-write integer register file with a hardwired-zero x0.
// Contents clear asynchronously on rst_n low; reads are purely combinational.
module register_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_ena,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wr_sel;

  assign w_regs[0]   = '0;
  assign w_wr_sel[0] = 1'b0;

  // Per-register flops: the async clear rules out a RAM macro.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_q;

    assign w_wr_sel[gi] = write_ena && (rd_addr == ADDR_WIDTH'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_wr_sel[gi]) begin
        r_q <= rd_data;
      end
    end

    assign w_regs[gi] = r_q;
  end

  assign rs1_data = rst_n ? w_regs[rs1_addr] : '0;
  assign rs2_data = rst_n ? w_regs[rs2_addr] : '0;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: timing, x0, gating, dual read, reset.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_ena;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int n_checks = 0;
  int n_fails  = 0;

  register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_ena(write_ena),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Drive a write after the falling edge, let one rising edge commit it.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic ena);
    @(negedge clk);
    rd_addr   = addr;
    rd_data   = data;
    write_ena = ena;
    @(posedge clk);
    #1;
    write_ena = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    write_ena = 1'b0;
    rd_addr   = '0;
    rd_data   = '0;
    rs1_addr  = 5'd1;
    rs2_addr  = 5'd31;
    #12;
    check_eq("reset_rs1_x1", rs1_data, 32'h0);
    check_eq("reset_rs2_x31", rs2_data, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Write timing: old value before the edge, new value just after.
    @(negedge clk);
    rd_addr   = 5'd1;
    rd_data   = 32'h12345678;
    write_ena = 1'b1;
    rs1_addr  = 5'd1;
    #1;
    check_eq("x1_before_edge", rs1_data, 32'h0);
    @(posedge clk);
    #1;
    check_eq("x1_after_edge", rs1_data, 32'h12345678);
    write_ena = 1'b0;

    do_write(5'd0, 32'hDEADBEEF, 1'b1);
    read_pair(5'd0, 5'd0);
    check_eq("x0_rs1", rs1_data, 32'h0);
    check_eq("x0_rs2", rs2_data, 32'h0);

    do_write(5'd2, 32'hFFFFFFFF, 1'b0);
    read_pair(5'd2, 5'd2);
    check_eq("x2_gated", rs1_data, 32'h0);

    do_write(5'd3, 32'h11111111, 1'b1);
    do_write(5'd31, 32'h22222222, 1'b1);
    read_pair(5'd3, 5'd31);
    check_eq("dual_rs1_x3", rs1_data, 32'h11111111);
    check_eq("dual_rs2_x31", rs2_data, 32'h22222222);
    read_pair(5'd31, 5'd3);
    check_eq("swap_rs1_x31", rs1_data, 32'h22222222);
    check_eq("swap_rs2_x3", rs2_data, 32'h11111111);
    read_pair(5'd31, 5'd31);
    check_eq("same_rs1_x31", rs1_data, 32'h22222222);
    check_eq("same_rs2_x31", rs2_data, 32'h22222222);

    do_write(5'd1, 32'hCAFEBABE, 1'b1);
    read_pair(5'd1, 5'd3);
    check_eq("overwrite_x1", rs1_data, 32'hCAFEBABE);
    check_eq("keep_x3", rs2_data, 32'h11111111);
    read_pair(5'd2, 5'd31);
    check_eq("keep_x2", rs1_data, 32'h0);
    check_eq("keep_x31", rs2_data, 32'h22222222);

    // Mid-cycle asynchronous reset after x5 is written.
    do_write(5'd5, 32'hA5A5A5A5, 1'b1);
    read_pair(5'd5, 5'd1);
    check_eq("x5_written", rs1_data, 32'hA5A5A5A5);
    @(negedge clk);
    rd_addr   = 5'd6;
    rd_data   = 32'h66666666;
    write_ena = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("x5_async_clear", rs1_data, 32'h0);
    for (int a = 0; a < 32; a++) begin
      read_pair(5'(a), 5'(31 - a));
      check_eq($sformatf("rst_rs1_x%0d", a), rs1_data, 32'h0);
      check_eq($sformatf("rst_rs2_x%0d", 31 - a), rs2_data, 32'h0);
    end
    @(posedge clk);
    #1;
    write_ena = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    read_pair(5'd6, 5'd5);
    check_eq("x6_blocked_by_reset", rs1_data, 32'h0);
    check_eq("x5_after_reset", rs2_data, 32'h0);

    do_write(5'd7, 32'h0BADF00D, 1'b1);
    read_pair(5'd7, 5'd1);
    check_eq("first_write_after_reset", rs1_data, 32'h0BADF00D);
    check_eq("x1_after_reset", rs2_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register and data-port width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, address width (2^ADDR_WIDTH registers; 32 by default).
REQ-003 SHALL provide clk  input  1  sole clock; all register writes occur on its rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide write_ena  input  1  write enable, sampled at rising clk.
REQ-006 SHALL provide rd_addr  input  ADDR_WIDTH  write (destination) register index.
REQ-007 SHALL provide rd_data  input  DATA_WIDTH  write data.
REQ-008 SHALL provide rs1_addr  input  ADDR_WIDTH  read port 1 register index.
REQ-009 SHALL provide rs2_addr  input  ADDR_WIDTH  read port 2 register index.
REQ-010 SHALL provide rs1_data  output  DATA_WIDTH  contents of register rs1_addr.
REQ-011 SHALL provide rs2_data  output  DATA_WIDTH  contents of register rs2_addr.

Function
REQ-012 SHALL hold 2^ADDR_WIDTH registers x0..x31 of DATA_WIDTH bits each.
REQ-013 SHALL write rd_data into register rd_addr on rising clk when write_ena=1, rst_n=1 and rd_addr!=0.
REQ-014 SHALL leave all registers unchanged on rising clk when write_ena=0.
REQ-015 SHALL treat x0 as hardwired zero: writes to rd_addr=0 are discarded; reads of x0 return 0 on either port at all times.
REQ-016 SHALL drive rs1_data and rs2_data combinationally from rs1_addr/rs2_addr and the current register contents, with zero-cycle latency and no clock dependence.
REQ-017 SHALL provide no write-to-read bypass: while a write to register N is pending (before the rising edge), a read of N returns the old value; the new value appears on the read port immediately after that edge.
REQ-018 SHALL allow both read ports to address the same register, including x0 and the register being written, each returning the same value.
REQ-019 SHALL perform at most one write per clock cycle; the read ports never modify state.
REQ-020 SHALL not produce X on the read outputs once reset has been asserted at least once.

Reset
REQ-021 SHALL clear all registers to 0 immediately when rst_n goes low, without waiting for clk.
REQ-022 SHALL block writes while rst_n=0, including when write_ena=1.
REQ-023 SHALL drive rs1_data=rs2_data=0 for every address while rst_n=0.
REQ-024 SHALL give reset priority over a write in the same cycle: if rst_n falls during a pending write, the register stays 0.
REQ-025 SHALL accept the first write on the first rising clk after rst_n returns high.

Verification
REQ-026 Bench SHALL cover reset: assert rst_n=0 mid-cycle after writing x5=0xA5A5A5A5 -> x5 and all registers read 0 before the next clk edge.
REQ-027 Bench SHALL cover write/read timing: after reset, rd_addr=1, rd_data=0x12345678, write_ena=1, rs1_addr=1 -> rs1_data=0x00000000 before the edge and 0x12345678 1 time unit after the rising edge.
REQ-028 Bench SHALL cover x0 protection: rd_addr=0, rd_data=0xDEADBEEF, write_ena=1, one edge -> rs1_data=0x00000000 for rs1_addr=0.
REQ-029 Bench SHALL cover write-enable gating: write_ena=0, rd_addr=2, rd_data=0xFFFFFFFF, one edge -> x2 reads 0x00000000.
REQ-030 Bench SHALL cover dual-port read: write x3=0x11111111 and x31=0x22222222; set rs1_addr=3, rs2_addr=31 -> 0x11111111 / 0x22222222; swap addresses -> the outputs swap in the same cycle.
REQ-031 Bench SHALL cover overwrite: write x1=0xCAFEBABE after x1=0x12345678 -> reads 0xCAFEBABE after the edge; other registers are unchanged.
